// File: rtl/vector_mem_ctrl_if.sv
// CPU-side request/response channel of the vector memory controller.
// The CPU drives the master modport and the controller uses the slave modport.
interface vector_mem_ctrl_if #(
    parameter int LANES    = 8,
    parameter int ELEM_W   = 8,
    parameter int ADDR_W   = 12,
    parameter int STRIDE_W = 4
) ();
    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_op;
    logic [ADDR_W-1:0]         req_addr;
    logic [STRIDE_W-1:0]       req_stride;
    logic [LANES*ELEM_W-1:0]   req_wdata;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [LANES*ELEM_W-1:0]   resp_data;

    modport master (
        output req_valid, req_op, req_addr, req_stride, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_stride, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/vector_mem_ctrl.sv
// Load/store sequencer: splits one CPU request into per-element byte memory
// cycles at base + idx*stride and gathers load bytes into a vector response.
module vector_mem_ctrl #(
    parameter int LANES    = 8,
    parameter int ELEM_W   = 8,
    parameter int ADDR_W   = 12,
    parameter int STRIDE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    vector_mem_ctrl_if.slave    cpu,
    output logic                busy,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [ELEM_W-1:0]   mem_wdata,
    input  logic [ELEM_W-1:0]   mem_rdata
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int OFF_W = IDX_W + STRIDE_W;
    localparam int SUM_W = ADDR_W + OFF_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESP} state_t;

    state_t                    state;
    logic                      is_store;
    logic [ADDR_W-1:0]         base_q;
    logic [STRIDE_W-1:0]       stride_q;
    logic [LANES*ELEM_W-1:0]   wdata_q;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          last_idx;
    logic [IDX_W-1:0]          next_idx;
    logic [IDX_W-1:0]          prev_idx;

    // Full-width offset, then truncation to the address width so addresses wrap.
    function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0]   base,
                                                    input logic [STRIDE_W-1:0] stride,
                                                    input logic [IDX_W-1:0]    i);
        logic [OFF_W-1:0] offset;
        logic [SUM_W-1:0] full;
        offset = OFF_W'(i) * OFF_W'(stride);
        full   = SUM_W'(base) + SUM_W'(offset);
        return full[ADDR_W-1:0];
    endfunction

    always_comb begin
        next_idx = idx + IDX_W'(1);
        prev_idx = idx - IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            cpu.req_ready  <= 1'b1;
            cpu.resp_valid <= 1'b0;
            cpu.resp_data  <= '0;
            busy           <= 1'b0;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            idx            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu.req_valid) begin
                        is_store      <= cpu.req_op[0];
                        base_q        <= cpu.req_addr;
                        stride_q      <= cpu.req_op[1] ? cpu.req_stride : '0;
                        wdata_q       <= cpu.req_wdata;
                        last_idx      <= cpu.req_op[1] ? IDX_W'(LANES - 1) : '0;
                        idx           <= '0;
                        cpu.resp_data <= '0;
                        // Element 0 is presented in the first RUN cycle.
                        mem_addr      <= cpu.req_addr;
                        mem_re        <= ~cpu.req_op[0];
                        mem_we        <= cpu.req_op[0];
                        mem_wdata     <= cpu.req_wdata[ELEM_W-1:0];
                        cpu.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        state         <= RUN;
                    end
                end

                RUN: begin
                    // Registered memory read: this cycle's rdata belongs to the previous element.
                    if (!is_store && idx != '0)
                        cpu.resp_data[prev_idx*ELEM_W +: ELEM_W] <= mem_rdata;
                    if (idx == last_idx) begin
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        if (is_store) begin
                            cpu.resp_valid <= 1'b1;
                            state          <= RESP;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        idx       <= next_idx;
                        mem_addr  <= elem_addr(base_q, stride_q, next_idx);
                        mem_wdata <= wdata_q[next_idx*ELEM_W +: ELEM_W];
                    end
                end

                DRAIN: begin
                    cpu.resp_data[last_idx*ELEM_W +: ELEM_W] <= mem_rdata;
                    cpu.resp_valid <= 1'b1;
                    state          <= RESP;
                end

                RESP: begin
                    if (cpu.resp_ready) begin
                        cpu.resp_valid <= 1'b0;
                        cpu.req_ready  <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_mem_ctrl.sv
// Scoreboard bench for vector_mem_ctrl: a reference memory image predicts every
// memory access and every response; monitors compare against the DUT.
module tb_vector_mem_ctrl;
    localparam int LANES    = 8;
    localparam int ELEM_W   = 8;
    localparam int ADDR_W   = 12;
    localparam int STRIDE_W = 4;
    localparam int W        = LANES * ELEM_W;
    localparam int MSIZE    = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                busy;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_re;
    logic                mem_we;
    logic [ELEM_W-1:0]   mem_wdata;
    logic [ELEM_W-1:0]   mem_rdata;

    vector_mem_ctrl_if #(.LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) cpu_if ();

    vector_mem_ctrl #(.LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (cpu_if.slave),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] data; int lat; int acc; } resp_t;
    typedef struct { int addr; bit we; int wd; } access_t;

    resp_t   rq[$];
    access_t aq[$];
    int      checks = 0;
    int      fails  = 0;
    int      cyc    = 0;
    int      rr_mode = 0;
    logic [ELEM_W-1:0] mem      [MSIZE];
    logic [ELEM_W-1:0] init_img [MSIZE];
    logic [ELEM_W-1:0] ref_mem  [MSIZE];
    logic              init_req;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory with one-cycle registered read.
    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < MSIZE; k++) mem[k] <= init_img[k];
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Response backpressure generator.
    initial begin
        cpu_if.resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rr_mode)
                0:       cpu_if.resp_ready = 1'b1;
                1:       cpu_if.resp_ready = ($urandom_range(0, 2) != 0);
                default: cpu_if.resp_ready = 1'b0;
            endcase
        end
    end

    // Memory bus monitor.
    initial begin
        access_t x;
        forever begin
            @(negedge clk);
            if (mem_re && mem_we) fail_msg("re_we_both_high");
            if (mem_re || mem_we) begin
                if (aq.size() == 0) begin
                    fail_msg("unexpected_mem_access");
                end else begin
                    x = aq.pop_front();
                    chk("mem_addr", W'(mem_addr), W'(x.addr));
                    chk("mem_we", W'(mem_we), W'(x.we));
                    if (x.we) chk("mem_wdata", W'(mem_wdata), W'(x.wd));
                end
            end
        end
    end

    // Response monitor.
    initial begin
        bit           in_resp = 0;
        logic [W-1:0] held;
        resp_t        e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                in_resp = 0;
            end else if (cpu_if.resp_valid) begin
                chk("req_ready_in_resp", W'(cpu_if.req_ready), '0);
                chk("busy_in_resp", W'(busy), W'(1));
                if (!in_resp) begin
                    in_resp = 1;
                    held = cpu_if.resp_data;
                    if (rq.size() == 0) fail_msg("unexpected_resp");
                    else chk("resp_latency", W'(cyc + 1 - rq[0].acc), W'(rq[0].lat));
                end else begin
                    chk("resp_stable", cpu_if.resp_data, held);
                end
                if (cpu_if.resp_ready) begin
                    in_resp = 0;
                    if (rq.size() > 0) begin
                        e = rq.pop_front();
                        chk("resp_data", cpu_if.resp_data, e.data);
                    end
                end
            end else if (in_resp) begin
                fail_msg("resp_dropped_before_handshake");
                in_resp = 0;
            end
        end
    end

    task automatic wait_ready();
        int k;
        for (k = 0; k < 200; k++) begin
            if (cpu_if.req_ready === 1'b1) break;
            @(negedge clk);
        end
        if (k == 200) fail_msg("req_ready_timeout");
    endtask

    // Issues one request and records the model's expectations (called at a negedge).
    task automatic do_op(input logic [1:0] op, input int base, input int stride, input logic [W-1:0] wd);
        int      n, st, a;
        resp_t   r;
        access_t x;
        wait_ready();
        n = op[1] ? LANES : 1;
        st = op[1] ? stride : 0;
        r.data = '0;
        for (int i = 0; i < n; i++) begin
            a = (base + i * st) % MSIZE;
            x.addr = a;
            x.we = op[0];
            x.wd = op[0] ? int'(wd[i*ELEM_W +: ELEM_W]) : 0;
            aq.push_back(x);
            if (op[0]) ref_mem[a] = wd[i*ELEM_W +: ELEM_W];
            else       r.data[i*ELEM_W +: ELEM_W] = ref_mem[a];
        end
        r.lat = op[0] ? n + 1 : n + 2;
        r.acc = cyc + 1;
        rq.push_back(r);
        cpu_if.req_valid  = 1'b1;
        cpu_if.req_op     = op;
        cpu_if.req_addr   = ADDR_W'(base);
        cpu_if.req_stride = STRIDE_W'(stride);
        cpu_if.req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        cpu_if.req_valid  = 1'b0;
    endtask

    initial begin
        int k;
        access_t x;
        logic [W-1:0] wd;
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        access_t x;
        logic [W-1:0] wd;
        rst = 1'b0;
        init_req = 1'b1;
        cpu_if.req_valid  = 1'b1;
        cpu_if.req_op     = 2'b10;
        cpu_if.req_addr   = '0;
        cpu_if.req_stride = 4'd1;
        cpu_if.req_wdata  = '0;
        for (int i = 0; i < MSIZE; i++) init_img[i] = ELEM_W'($urandom);
        for (int i = 0; i < LANES; i++) init_img[16 + i] = ELEM_W'(8'hA0 + i);
        init_img[12'h020] = 8'h5C;
        ref_mem = init_img;

        // Reset held two cycles with a request pending.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            init_req = 1'b0;
            chk("rst_req_ready", W'(cpu_if.req_ready), W'(1));
            chk("rst_busy", W'(busy), '0);
            chk("rst_resp_valid", W'(cpu_if.resp_valid), '0);
            chk("rst_mem_re", W'(mem_re), '0);
            chk("rst_mem_we", W'(mem_we), '0);
            chk("rst_resp_data", cpu_if.resp_data, '0);
            chk("rst_mem_addr", W'(mem_addr), '0);
        end
        cpu_if.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", W'(busy), '0);

        // Unit-stride vector load; the constant pins the expected gather result.
        do_op(2'b10, 12'h010, 1, '0);
        chk("vload_model_const", rq[rq.size()-1].data, 64'hA7A6A5A4A3A2A1A0);
        // Strided load wrapping past the top of memory.
        do_op(2'b10, 12'hFFE, 3, '0);
        // Vector store then reload with the same pattern.
        do_op(2'b11, 12'h100, 2, 64'h0123456789ABCDEF);
        do_op(2'b10, 12'h100, 2, '0);
        // Stride 0: replicated load, last-lane-wins store.
        do_op(2'b10, 12'h020, 0, '0);
        do_op(2'b11, 12'h300, 0, 64'h1122334455667788);
        do_op(2'b00, 12'h300, 7, '0);

        // Word load held in RESP with resp_ready low; stray requests must be ignored.
        wait_ready();
        rr_mode = 2;
        do_op(2'b00, 12'h020, 5, '0);
        chk("wload_model_const", rq[rq.size()-1].data, 64'h5C);
        for (k = 0; k < 50 && cpu_if.resp_valid !== 1'b1; k++) @(negedge clk);
        if (k == 50) fail_msg("wload_resp_timeout");
        cpu_if.req_valid = 1'b1;
        cpu_if.req_op    = 2'b11;
        repeat (5) @(negedge clk);
        cpu_if.req_valid = 1'b0;
        rr_mode = 0;

        // Reset during a vector store, in the cycle lane 3 would be issued.
        wait_ready();
        wd = 64'hF7F6F5F4F3F2F1F0;
        for (int i = 0; i < 3; i++) begin
            x.addr = 12'h200 + i;
            x.we = 1'b1;
            x.wd = int'(wd[i*ELEM_W +: ELEM_W]);
            aq.push_back(x);
            ref_mem[12'h200 + i] = wd[i*ELEM_W +: ELEM_W];
        end
        cpu_if.req_valid  = 1'b1;
        cpu_if.req_op     = 2'b11;
        cpu_if.req_addr   = 12'h200;
        cpu_if.req_stride = 4'd1;
        cpu_if.req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        cpu_if.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_mem_we", W'(mem_we), '0);
        chk("midrst_busy", W'(busy), '0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", W'(cpu_if.req_ready), W'(1));
        repeat (4) @(negedge clk);
        chk("midrst_no_more_writes", W'(aq.size()), '0);
        do_op(2'b10, 12'h200, 1, '0);

        // Randomized traffic with random response backpressure.
        for (int t = 0; t < 40; t++) begin
            rr_mode = $urandom_range(0, 1);
            do_op(2'($urandom_range(0, 3)), int'($urandom_range(0, MSIZE - 1)),
                  int'($urandom_range(0, 15)), {$urandom, $urandom});
        end
        rr_mode = 0;

        for (k = 0; k < 200 && (rq.size() != 0 || cpu_if.req_ready !== 1'b1); k++) @(negedge clk);
        chk("resp_queue_drained", W'(rq.size()), '0);
        chk("access_queue_drained", W'(aq.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/vector_mem_ctrl.md
Name: vector_mem_ctrl

Overview:
Parametrised load/store sequencer between the CPU and a byte-wide main memory. It replaces the fixed 64-bit vector/word memory path. The CPU issues a single request through a valid/ready handshake. The block sequences it into per-element memory cycles using base + index*stride addressing, which gives strided gather and scatter. Load results are assembled into a LANES-wide vector and returned through a valid/ready response.

Parameters:
LANES, 8, elements per vector access
ELEM_W, 8, element width in bits (equals memory data width)
ADDR_W, 12, main memory address width
STRIDE_W, 4, width of the unsigned element stride

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
req_valid  input  1  CPU request valid
req_ready  output  1  controller can accept a request
req_op  input  2  00 load word, 01 store word, 10 load vector, 11 store vector
req_addr  input  ADDR_W  base address
req_stride  input  STRIDE_W  element stride; used only for vector ops
req_wdata  input  LANES*ELEM_W  store data; lane i = bits [i*ELEM_W +: ELEM_W]
resp_valid  output  1  operation complete
resp_ready  input  1  CPU accepts response
resp_data  output  LANES*ELEM_W  load result; zero for stores
busy  output  1  high in any state other than IDLE
mem_addr  output  ADDR_W  memory address
mem_re  output  1  memory read strobe
mem_we  output  1  memory write strobe
mem_wdata  output  ELEM_W  memory write data
mem_rdata  input  ELEM_W  memory read data; valid one cycle after mem_re (registered read)

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; req_ready=1; resp_valid=0; resp_data=0; busy=0; mem_re=mem_we=0; mem_addr=0; mem_wdata=0. Reset overrides every other input.
- All outputs are registered.
- States: IDLE, RUN, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge T: latch op, base, stride, and wdata. Clear the result vector. Set N=1 for word ops, N=LANES for vector ops. For word ops, stride is forced to 0. idx=0. Go to RUN.
- RUN:
  - Runs for cycles T+1 .. T+N. In cycle T+1+i, element i is issued: mem_addr = (base + i*stride) mod 2^ADDR_W. The product is computed at full width, then truncated, so the address wraps.
  - Loads: mem_re=1. mem_rdata is captured into lane i-1 in the cycle following each issue.
  - Stores: mem_we=1, mem_wdata = latched lane i.
  - After element N-1: loads go to DRAIN, stores go to RESP.
- DRAIN (loads only):
  - One cycle. mem_re=0. Captures the last element into lane N-1. Go to RESP.
- RESP:
  - resp_valid=1 and resp_data stable until the edge where resp_ready=1, then return to IDLE.
  - req_ready=0 in RUN, DRAIN and RESP. No new request is accepted until the cycle after the response handshake.
- Latency, with accept at edge T and resp_ready held high:
  - Loads: resp_valid first high at cycle T+N+2.
  - Stores: resp_valid first high at cycle T+N+1.
  - Vector load, LANES=8: resp_valid at T+10. Word load: resp_valid at T+3.
- Word load places the byte in lane 0; all other lanes are 0. Word store writes lane 0 only.
- Stride 0 on a vector op is legal. Every element accesses the base address: loads replicate the byte; for stores, the last lane wins.
- mem_re and mem_we are never both high. Both are low outside RUN.
- Reset mid-operation: the operation is abandoned at that edge. No further mem_we pulses are issued and no response is produced. Memory writes already issued remain.
- Inputs other than rst and resp_ready are ignored outside IDLE.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_valid=1 -> req_ready=1, busy=0, resp_valid=0, mem_re=mem_we=0. No request is accepted while in reset.
- Vector load, base 0x010, stride 1, mem[0x010+i]=0xA0+i -> mem_addr 0x010..0x017 on consecutive cycles; resp_valid at T+10; resp_data=0xA7A6A5A4A3A2A1A0.
- Strided wrap: vector load, base 0xFFE, stride 3 -> addresses 0xFFE, 0x001, 0x004, 0x007, 0x00A, 0x00D, 0x010, 0x013; lanes match the memory contents at those addresses.
- Store then load: vector store of 0x0123456789ABCDEF at base 0x100, stride 2 -> 8 mem_we pulses at even addresses; resp_valid at T+9; a reload with the same base and stride returns identical data.
- Word load from mem[0x020]=0x5C -> resp_data=0x000000000000005C; resp_valid at T+3. Hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0 throughout.
- Reset mid-store: assert rst=0 in the cycle lane 3 would issue -> only lanes 0-2 written, resp_valid never asserts, state returns to IDLE.
